// File: rtl/pe_array_pkg.sv
// ----------------------------------------------------------------------------
// pe_array_pkg
// Shared encodings for the PE array control path: array command codes, shift
// directions, image selects, sequencer state encodings and the sequencer's
// program-step selector. pe_message_passer decodes the same command and
// direction constants, so the numeric values here must not change.
// ----------------------------------------------------------------------------
package pe_array_pkg;

    // Array command codes driven on command_to_execute
    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_LOAD  = 3'd1;
    localparam logic [2:0] CMD_SHIFT = 3'd2;
    localparam logic [2:0] CMD_MAC   = 3'd3;
    localparam logic [2:0] CMD_CLEAR = 3'd4;

    // Shift directions driven on shift_direction
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Image selects driven on image_to_shift
    localparam logic IMG_A = 1'b0;
    localparam logic IMG_B = 1'b1;

    // Sequencer top-level states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ACK   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } seq_state_t;

    // Program step currently being (or about to be) issued
    typedef enum logic [2:0] {
        NC_CLEAR = 3'd0,
        NC_LOAD  = 3'd1,
        NC_MAC   = 3'd2,
        NC_SHA   = 3'd3,
        NC_SHB   = 3'd4
    } seq_cmd_t;

    // One complete word presented to the array
    typedef struct packed {
        logic [2:0] cmd;
        logic [1:0] dir;
        logic       img;
    } array_word_t;

    // Map a program step to the array word; dir/img stay zero unless SHIFT
    function automatic array_word_t seq_cmd_decode(input seq_cmd_t step);
        array_word_t w;
        w.cmd = CMD_NOP;
        w.dir = DIR_UP;
        w.img = IMG_A;
        case (step)
            NC_CLEAR: w.cmd = CMD_CLEAR;
            NC_LOAD:  w.cmd = CMD_LOAD;
            NC_MAC:   w.cmd = CMD_MAC;
            NC_SHA: begin
                w.cmd = CMD_SHIFT;
                w.dir = DIR_LEFT;
                w.img = IMG_A;
            end
            NC_SHB: begin
                w.cmd = CMD_SHIFT;
                w.dir = DIR_UP;
                w.img = IMG_B;
            end
            default: w.cmd = CMD_NOP;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pe_cmd_watchdog.sv
// ----------------------------------------------------------------------------
// pe_cmd_watchdog
// Loadable down-counter guarding one array command. Loaded on `clear` (the
// edge entering CMD) so that `expired` rises in the TIMEOUT-th cycle of the
// command; the sequencer then leaves CMD on that cycle's closing edge.
// Ports:
//   CLK     in  clock, rising edge
//   RST_N   in  synchronous active-low reset
//   clear   in  reload the counter (command entry)
//   enable  in  count this cycle (command waiting)
//   expired out budget used up while enabled
// ----------------------------------------------------------------------------
module pe_cmd_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Remaining-cycle counter: reload on command entry, count down while waiting
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_count <= CNT_ZERO;
        end else if (clear) begin
            r_count <= LOAD_VAL;
        end else if (enable && (r_count != CNT_ZERO)) begin
            r_count <= r_count - CNT_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign expired = enable && (r_count == CNT_ZERO);

endmodule

// File: rtl/pe_array_sequencer.sv
// ----------------------------------------------------------------------------
// pe_array_sequencer
// Runs the Cannon-style program CLEAR, LOAD, then N x (MAC, SHIFT A left,
// SHIFT B up) with the final pair of shifts omitted, handshaking each command
// with the PE array over array_ready / array_ack.
// Ports:
//   CLK, RST_N          clock, synchronous active-low reset
//   start, num_iter     host launch and MAC count (taken in IDLE/ERROR only)
//   array_ready         array reports current command complete
//   array_ack           one-cycle acknowledge back to the array
//   command_to_execute  array command, shift_direction / image_to_shift
//   busy, done, error   program running / end pulse / sticky watchdog trip
//   iter_count          MACs completed in the current run
// All outputs are registered and derived from the next-state decision.
// ----------------------------------------------------------------------------
module pe_array_sequencer #(
    parameter int unsigned ARRAY_SIZE_1D = 1,
    parameter int unsigned ITER_W        = 8,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [ITER_W-1:0] num_iter,
    input  logic              array_ready,
    output logic              array_ack,
    output logic [2:0]        command_to_execute,
    output logic [1:0]        shift_direction,
    output logic              image_to_shift,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ITER_W-1:0] iter_count
);

    import pe_array_pkg::*;

    if ((TIMEOUT < 2) || (ARRAY_SIZE_1D < 1)) begin : g_bad_params
        $error("pe_array_sequencer: TIMEOUT must be >= 2 and ARRAY_SIZE_1D >= 1");
    end

    localparam logic [ITER_W-1:0] ITER_ZERO = {ITER_W{1'b0}};
    localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);

    seq_state_t        r_state;
    seq_cmd_t          r_next_cmd;
    logic [ITER_W-1:0] r_num_iter;
    logic [ITER_W-1:0] r_iter;
    logic              r_first;
    logic [2:0]        r_cmd;
    logic [1:0]        r_dir;
    logic              r_img;
    logic              r_ack;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    seq_state_t        w_state_nxt;
    seq_cmd_t          w_next_cmd_nxt;
    logic [ITER_W-1:0] w_num_iter_nxt;
    logic [ITER_W-1:0] w_iter_nxt;
    array_word_t       w_word;
    logic              w_wd_clear;
    logic              w_wd_expired;

    // Reload the watchdog on the edge that enters CMD
    assign w_wd_clear = (w_state_nxt == ST_CMD) && (r_state != ST_CMD);

    pe_cmd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .clear   (w_wd_clear),
        .enable  (r_state == ST_CMD),
        .expired (w_wd_expired)
    );

    // Next-state, program step, iteration bookkeeping and next output word
    always_comb begin
        w_state_nxt    = r_state;
        w_next_cmd_nxt = r_next_cmd;
        w_num_iter_nxt = r_num_iter;
        w_iter_nxt     = r_iter;
        case (r_state)
            ST_IDLE, ST_ERROR: begin
                if (start) begin
                    w_state_nxt    = ST_CMD;
                    w_next_cmd_nxt = NC_CLEAR;
                    w_num_iter_nxt = num_iter;
                    w_iter_nxt     = ITER_ZERO;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_CMD: begin
                // r_first marks the settle cycle, where ready is not trusted
                if (!r_first && array_ready) begin
                    w_state_nxt = ST_ACK;
                    if (r_next_cmd == NC_MAC) begin
                        w_iter_nxt = r_iter + ITER_ONE;
                    end else begin
                        w_iter_nxt = r_iter;
                    end
                end else if (w_wd_expired) begin
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_state_nxt = ST_CMD;
                end
            end
            ST_ACK: begin
                case (r_next_cmd)
                    NC_CLEAR: begin
                        w_state_nxt    = ST_CMD;
                        w_next_cmd_nxt = NC_LOAD;
                    end
                    NC_LOAD: begin
                        if (r_num_iter == ITER_ZERO) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt    = ST_CMD;
                            w_next_cmd_nxt = NC_MAC;
                        end
                    end
                    NC_MAC: begin
                        // r_iter already counts the MAC just acknowledged
                        if (r_iter < r_num_iter) begin
                            w_state_nxt    = ST_CMD;
                            w_next_cmd_nxt = NC_SHA;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                    NC_SHA: begin
                        w_state_nxt    = ST_CMD;
                        w_next_cmd_nxt = NC_SHB;
                    end
                    NC_SHB: begin
                        w_state_nxt    = ST_CMD;
                        w_next_cmd_nxt = NC_MAC;
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase

        if (w_state_nxt == ST_CMD) begin
            w_word = seq_cmd_decode(w_next_cmd_nxt);
        end else begin
            w_word = '{cmd: CMD_NOP, dir: DIR_UP, img: IMG_A};
        end
    end

    // State, bookkeeping and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_next_cmd <= NC_CLEAR;
            r_num_iter <= ITER_ZERO;
            r_iter     <= ITER_ZERO;
            r_first    <= 1'b0;
            r_cmd      <= CMD_NOP;
            r_dir      <= DIR_UP;
            r_img      <= IMG_A;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_next_cmd <= w_next_cmd_nxt;
            r_num_iter <= w_num_iter_nxt;
            r_iter     <= w_iter_nxt;
            r_first    <= w_wd_clear;
            r_cmd      <= w_word.cmd;
            r_dir      <= w_word.dir;
            r_img      <= w_word.img;
            r_ack      <= (w_state_nxt == ST_ACK);
            r_busy     <= (w_state_nxt == ST_CMD) || (w_state_nxt == ST_ACK);
            r_done     <= (w_state_nxt == ST_DONE);
            r_error    <= (w_state_nxt == ST_ERROR);
        end
    end

    assign array_ack          = r_ack;
    assign command_to_execute = r_cmd;
    assign shift_direction    = r_dir;
    assign image_to_shift     = r_img;
    assign busy               = r_busy;
    assign done               = r_done;
    assign error              = r_error;
    assign iter_count         = r_iter;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pe_array_sequencer
// Directed bench for pe_array_sequencer (TIMEOUT = 10). Cycle 1 is the first
// cycle after the edge that samples start; outputs are sampled on the falling
// edge and inputs are driven right after sampling.
// ----------------------------------------------------------------------------
module tb_pe_array_sequencer;

    localparam int unsigned ITER_W  = 8;
    localparam int unsigned TIMEOUT = 10;

    // {cmd, dir, img} words as seen on the array interface
    localparam logic [5:0] W_NOP   = 6'b000_00_0;
    localparam logic [5:0] W_CLEAR = 6'b100_00_0;
    localparam logic [5:0] W_LOAD  = 6'b001_00_0;
    localparam logic [5:0] W_MAC   = 6'b011_00_0;
    localparam logic [5:0] W_SHA   = 6'b010_10_0;
    localparam logic [5:0] W_SHB   = 6'b010_00_1;

    logic              CLK;
    logic              RST_N;
    logic              start;
    logic [ITER_W-1:0] num_iter;
    logic              array_ready;
    logic              array_ack;
    logic [2:0]        command_to_execute;
    logic [1:0]        shift_direction;
    logic              image_to_shift;
    logic              busy;
    logic              done;
    logic              error;
    logic [ITER_W-1:0] iter_count;

    int n_vec;
    int n_fail;

    logic [5:0] got_q[$];
    logic [5:0] exp_q[$];

    typedef struct {
        logic [ITER_W-1:0] n;
        int                mac_delay;
        int                exp_done;
        int                exp_acks;
        logic [ITER_W-1:0] exp_iter;
    } vec_t;

    vec_t vecs[5];

    pe_array_sequencer #(
        .ARRAY_SIZE_1D (4),
        .ITER_W        (ITER_W),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .CLK                (CLK),
        .RST_N              (RST_N),
        .start              (start),
        .num_iter           (num_iter),
        .array_ready        (array_ready),
        .array_ack          (array_ack),
        .command_to_execute (command_to_execute),
        .shift_direction    (shift_direction),
        .image_to_shift     (image_to_shift),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .iter_count         (iter_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [5:0] cur_word();
        return {command_to_execute, shift_direction, image_to_shift};
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_cmd"},   32'(cur_word()), 32'(W_NOP));
        check({tag, "_ack"},   32'(array_ack), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_iter"},  32'(iter_count), 32'd0);
    endtask

    // Program order built independently from N
    task automatic build_expected(input int n);
        exp_q.delete();
        exp_q.push_back(W_CLEAR);
        exp_q.push_back(W_LOAD);
        for (int i = 1; i <= n; i++) begin
            exp_q.push_back(W_MAC);
            if (i < n) begin
                exp_q.push_back(W_SHA);
                exp_q.push_back(W_SHB);
            end
        end
    endtask

    // Launch a program from the current falling edge and follow it to done.
    // mac_delay >= 0 holds array_ready low for that many MAC cycles.
    task automatic run_program(input logic [ITER_W-1:0] n, input int mac_delay,
                               input int exp_done, input int exp_acks,
                               input logic [ITER_W-1:0] exp_iter, input string tag);
        int         c;
        int         done_c;
        int         acks;
        int         mac_cyc;
        logic [5:0] prev;
        logic [5:0] cur;
        logic       prev_ack;
        logic       bad_stable;
        logic       bad_ack;
        logic       bad_busy;
        logic       bad_dir;
        logic       bad_err;
        int         n_cmp;

        got_q.delete();
        build_expected(int'(n));
        start       = 1'b1;
        num_iter    = n;
        array_ready = 1'b1;
        @(negedge CLK);
        start      = 1'b0;
        c          = 1;
        done_c     = -1;
        acks       = 0;
        mac_cyc    = 0;
        prev       = W_NOP;
        prev_ack   = 1'b0;
        bad_stable = 1'b0;
        bad_ack    = 1'b0;
        bad_busy   = 1'b0;
        bad_dir    = 1'b0;
        bad_err    = 1'b0;
        while ((done_c < 0) && (c <= 400)) begin
            cur = cur_word();
            if ((cur[5:3] != 3'd0) && (prev[5:3] == 3'd0)) got_q.push_back(cur);
            if ((cur[5:3] != 3'd0) && (prev[5:3] != 3'd0) && (cur != prev)) bad_stable = 1'b1;
            if ((cur[5:3] != 3'd2) && (cur[2:0] != 3'd0)) bad_dir = 1'b1;
            if (error) bad_err = 1'b1;
            if (array_ack) begin
                acks++;
                if (prev_ack || (cur != W_NOP)) bad_ack = 1'b1;
            end
            if (done) begin
                done_c = c;
                if (busy) bad_busy = 1'b1;
            end else if (!busy) begin
                bad_busy = 1'b1;
            end
            if ((mac_delay >= 0) && (cur == W_MAC)) begin
                array_ready = (mac_cyc >= mac_delay);
                mac_cyc++;
            end else begin
                array_ready = 1'b1;
                mac_cyc     = 0;
            end
            prev     = cur;
            prev_ack = array_ack;
            if (done_c < 0) begin
                @(negedge CLK);
                c++;
            end
        end
        check({tag, "_done_cycle"}, 32'(done_c), 32'(exp_done));
        check({tag, "_acks"}, 32'(acks), 32'(exp_acks));
        check({tag, "_iter_at_done"}, 32'(iter_count), 32'(exp_iter));
        check({tag, "_trace_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) begin
            check($sformatf("%s_trace%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check({tag, "_cmd_stable"}, 32'(bad_stable), 32'd0);
        check({tag, "_ack_shape"}, 32'(bad_ack), 32'd0);
        check({tag, "_busy_profile"}, 32'(bad_busy), 32'd0);
        check({tag, "_dir_img_zero"}, 32'(bad_dir), 32'd0);
        check({tag, "_no_error"}, 32'(bad_err), 32'd0);
        repeat (2) @(negedge CLK);
        check({tag, "_iter_hold"}, 32'(iter_count), 32'(exp_iter));
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_cmd"}, 32'(cur_word()), 32'(W_NOP));
    endtask

    initial begin
        int acks;

        n_vec  = 0;
        n_fail = 0;
        vecs[0] = '{n: 8'd2, mac_delay: -1, exp_done: 19, exp_acks: 6,  exp_iter: 8'd2};
        vecs[1] = '{n: 8'd0, mac_delay: -1, exp_done: 7,  exp_acks: 2,  exp_iter: 8'd0};
        vecs[2] = '{n: 8'd1, mac_delay: -1, exp_done: 10, exp_acks: 3,  exp_iter: 8'd1};
        vecs[3] = '{n: 8'd1, mac_delay: 5,  exp_done: 14, exp_acks: 3,  exp_iter: 8'd1};
        vecs[4] = '{n: 8'd4, mac_delay: -1, exp_done: 37, exp_acks: 12, exp_iter: 8'd4};

        RST_N       = 1'b0;
        start       = 1'b0;
        num_iter    = 8'd0;
        array_ready = 1'b0;
        repeat (3) @(negedge CLK);
        check_quiet("reset");
        RST_N = 1'b1;
        @(negedge CLK);

        for (int v = 0; v < 5; v++) begin
            run_program(vecs[v].n, vecs[v].mac_delay, vecs[v].exp_done,
                        vecs[v].exp_acks, vecs[v].exp_iter, $sformatf("vec%0d", v));
        end

        // Watchdog: ready only on the settle cycle, then never
        start       = 1'b1;
        num_iter    = 8'd1;
        array_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        acks  = 0;
        check("to_cmd_c1", 32'(cur_word()), 32'(W_CLEAR));
        array_ready = 1'b1;
        for (int c = 2; c <= 10; c++) begin
            @(negedge CLK);
            array_ready = 1'b0;
            if (array_ack) acks++;
            if (c == 10) begin
                check("to_cmd_c10", 32'(cur_word()), 32'(W_CLEAR));
                check("to_err_c10", 32'(error), 32'd0);
            end
        end
        @(negedge CLK);
        check("to_err_c11", 32'(error), 32'd1);
        check("to_cmd_c11", 32'(cur_word()), 32'(W_NOP));
        check("to_busy_c11", 32'(busy), 32'd0);
        repeat (5) begin
            @(negedge CLK);
            if (array_ack) acks++;
        end
        check("to_err_sticky", 32'(error), 32'd1);
        check("to_no_ack", 32'(acks), 32'd0);
        run_program(8'd1, -1, 10, 3, 8'd1, "restart");

        // Extra start while busy, then reset during SHIFT(A,LEFT) with N=3
        start       = 1'b1;
        num_iter    = 8'd3;
        array_ready = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
            if (c == 7) check("busy_start_mac", 32'(cur_word()), 32'(W_MAC));
            if (c == 10) check("rst_in_sha", 32'(cur_word()), 32'(W_SHA));
            if (c < 10) @(negedge CLK);
        end
        RST_N = 1'b0;
        @(negedge CLK);
        check_quiet("midrst1");
        @(negedge CLK);
        check_quiet("midrst2");
        RST_N = 1'b1;
        run_program(8'd3, -1, 28, 9, 8'd3, "fresh");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_array_sequencer.md
# pe_array_sequencer

Control sequencer for `pe_array`: on a host `start` pulse it runs a Cannon-style matrix-multiply program on the PE array. The program is clear, load, then repeated MAC / shift-A-left / shift-B-up steps. Each array command is issued over the array's ready/ack handshake. It sits between the host/top-level control and the `pe_array` command inputs (`command_to_execute`, `shift_direction`, `image_to_shift`, `array_ack`). A per-command watchdog detects a stalled array.

## Interface

Parameters:
- `ARRAY_SIZE_1D`, 1: array dimension; informational only, since host supplies iteration count.
- `ITER_W`, 8: width of iteration count.
- `TIMEOUT`, 255: max cycles a command may wait for `array_ready` (≥2).

Ports:
- `CLK`, in, 1: clock, rising edge.
- `RST_N`, in, 1: synchronous active-low reset.
- `start`, in, 1: begin program; sampled only in IDLE/ERROR.
- `num_iter`, in, ITER_W: MAC count N; latched on accepted `start`.
- `array_ready`, in, 1: from `pe_array.ready`; current command complete.
- `array_ack`, out, 1: to `pe_array.array_ack`; one-cycle acknowledge.
- `command_to_execute`, out, 3: array command.
- `shift_direction`, out, 2: shift direction for SHIFT.
- `image_to_shift`, out, 1: 0 = A, 1 = B.
- `busy`, out, 1: program running.
- `done`, out, 1: one-cycle pulse at program end.
- `error`, out, 1: sticky watchdog flag.
- `iter_count`, out, ITER_W: MACs completed in the current run.

## Operation

- Command encoding: NOP=0, LOAD=1, SHIFT=2, MAC=3, CLEAR=4.
- Direction encoding: UP=0, DOWN=1, LEFT=2, RIGHT=3.
- Program order: CLEAR, LOAD, then for i=1..N: MAC; if i<N, SHIFT(A, LEFT) then SHIFT(B, UP).
  - Total commands = 3N for N≥1.
  - N=0 runs CLEAR, LOAD only.
- States: IDLE, CMD, ACK, DONE, ERROR.
  - A `next_cmd` register selects CLEAR/LOAD/MAC/SHA/SHB.
- IDLE → CMD(CLEAR) on `start`; `num_iter` latched; `iter_count` cleared.
- CMD: drive the command/direction/image, hold them stable.
  - First cycle is a settle cycle; `array_ready` is ignored.
  - From the second cycle, `array_ready`=1 → ACK.
- ACK: `array_ack`=1 for exactly one cycle, command=NOP.
  - `iter_count` increments here if the command was MAC.
  - Then → CMD(next) or DONE.
- DONE: `done`=1 for one cycle, `busy`=0 → IDLE.
- Watchdog: cycle counter zeroed on CMD entry.
  - If the counter reaches TIMEOUT with no `array_ready`: → ERROR.
- ERROR: `error`=1 sticky, command=NOP, `array_ack`=0, `busy`=0.
  - `start` clears `error` and restarts the program (→ CMD(CLEAR)).
- `start` while busy: ignored.
- `array_ready` outside CMD: ignored.
- `shift_direction`/`image_to_shift` are 0 whenever the command ≠ SHIFT.

## Timing

- Reset (`RST_N`=0 at edge), takes effect at the next edge, including mid-program:
  - state IDLE, command NOP, all other outputs 0, `iter_count` 0.
  - No ack is emitted for the aborted command.
- `start` sampled at edge t0 → CLEAR on `command_to_execute` from t0+1.
- Per command, `array_ready` tied high: 3 cycles (settle, ready sampled, ack).
- Latency with `array_ready` tied high:
  - `done` high in cycle t0+9N+1 for N≥1.
  - `done` high in cycle t0+7 for N=0.
- `busy` is 1 from t0+1 through the last ACK cycle; 0 in the DONE cycle.
- `array_ready` high on the settle cycle only, then low: not accepted; command keeps waiting.
- Timeout: ERROR entered TIMEOUT cycles after CMD entry; `error` high the following cycle.
- `iter_count` saturates at N and holds after DONE until the next start.

## Structure

- Shared package `pe_array_pkg` holds the command encodings, direction encodings, image select constants and sequencer state encodings. `pe_message_passer` uses the same constants.
- One sub-module: `pe_cmd_watchdog`, a loadable down-counter.
  - Inputs: `clear`, `enable`. Output: `expired`.
  - Width $clog2(TIMEOUT+1).
- Sequencer FSM plus the iteration counter stay in `pe_array_sequencer`.

## Test plan

- Reset, then N=2, `array_ready` tied 1:
  - Command trace CLEAR, LOAD, MAC, SHIFT(A,LEFT), SHIFT(B,UP), MAC.
  - 6 single-cycle acks; `done` at t0+19; `iter_count`=2.
- N=0:
  - Only CLEAR, LOAD issued; `done` at t0+7; no MAC; `iter_count`=0.
- N=1, `array_ready` raised 5 cycles into MAC:
  - Command held stable through the wait; ack follows one cycle after ready sampled; `done` delayed accordingly.
- TIMEOUT=10, `array_ready` never asserted:
  - ERROR after 10 cycles in CLEAR; `error`=1 sticky; `array_ack` never pulses.
  - `start` clears `error` and reissues CLEAR.
- `start` pulsed while busy, and `RST_N` low during a SHIFT with N=3:
  - Extra start ignored.
  - After reset: all outputs 0, command NOP, no ack.
  - A fresh start runs the full program correctly.
